alu_arbiter2: RTL and testbench
===============================

Name: alu_arbiter2

Overview:
Two-requester arbiter that shares one combinational ALU datapath (cell array plus its 2:1 operand/select muxes) between two clients. Latches the winning client's operands and opcode, drives the shared ALU inputs and mux select for a programmable number of cycles, then captures the result and returns it with a one-cycle done pulse. Sits between the ALU cell array and the two client blocks of the practice datapath; round-robin fairness by default.

Parameters:
WIDTH, 4, operand/result width in bits
HOLD, 1, cycles the ALU inputs are held stable before the result is captured (legal range 1..15)

Ports:
clk  input  1  rising-edge clock, single clock domain
reset  input  1  synchronous, active-high reset
req0  input  1  client 0 request (level)
a0  input  WIDTH  client 0 operand A
b0  input  WIDTH  client 0 operand B
op0  input  2  client 0 ALU opcode
req1  input  1  client 1 request (level)
a1  input  WIDTH  client 1 operand A
b1  input  WIDTH  client 1 operand B
op1  input  2  client 1 ALU opcode
gnt0  output  1  one-cycle pulse: client 0 request captured
gnt1  output  1  one-cycle pulse: client 1 request captured
sel  output  1  owner of the ALU: 0 = client 0, 1 = client 1 (drives datapath mux select)
alu_a  output  WIDTH  operand A to shared ALU
alu_b  output  WIDTH  operand B to shared ALU
alu_op  output  2  opcode to shared ALU
alu_res  input  WIDTH  result from shared ALU
alu_cout  input  1  carry-out from shared ALU
busy  output  1  ALU owned (state BUSY)
done0  output  1  one-cycle pulse: result for client 0 valid
done1  output  1  one-cycle pulse: result for client 1 valid
res  output  WIDTH  captured result, held until next capture
cout  output  1  captured carry, held until next capture

Behaviour:
- Clock/reset: one clock (clk); reset synchronous, active-high; all state changes on rising clk.
- Reset values: gnt0=gnt1=done0=done1=busy=0, sel=0, alu_a=alu_b=0, alu_op=0, res=0, cout=0, state=IDLE, priority pointer=0 (client 0 first), hold counter=0.
- All outputs registered; no combinational path from any input to any output.
- States: IDLE, BUSY.
- IDLE, no req: stay; alu_* hold last values.
- IDLE, req0 or req1 at edge k: pick winner (only one requesting -> it; both -> client indicated by pointer). After edge k: state=BUSY, busy=1, sel=winner, alu_a/alu_b/alu_op = winner's inputs latched at edge k, gnt<winner>=1 for exactly one cycle, counter=HOLD-1. Loser's req ignored, not queued.
- BUSY: alu_* and sel stable. At each edge: counter>0 -> decrement; counter==0 -> res<=alu_res, cout<=alu_cout, done<sel>=1 for one cycle, busy=0, state=IDLE, pointer<=~sel.
- Latency: gnt visible cycle after request sampled; done visible HOLD cycles after gnt. Throughput: one operation per HOLD+1 cycles.
- req is level-sensitive: a request still high in IDLE after done is a new request; clients drop req on seeing gnt. Client inputs may change freely after gnt.
- Simultaneous request at both clients in consecutive ops: strict alternation (0,1,0,1...) from reset.
- done and a new gnt never occur in the same cycle.
- Reset mid-operation (BUSY): abort, no done pulse, all outputs to reset values next cycle.
- HOLD outside 1..15: elaboration-time error ($error/$finish in initial block).

Optional Feature:
ALU_ARB_FIXED_PRIO_EN: defined -> fixed priority, client 0 always wins on simultaneous requests; pointer register removed. Undefined (default) -> round-robin as above.

Test Plan:
- Reset: assert reset 2 cycles with req0=1 -> all outputs 0, no gnt; release -> gnt0 next cycle.
- Single op, HOLD=1, bench ALU op 00=add: req0=1, a0=3, b0=4, op0=00 -> gnt0 pulse, sel=0, alu_a=3, alu_b=4, done0 one cycle later, res=7, cout=0.
- Carry, HOLD=3: req1, a1=4'hF, b1=4'h1, op1=00 -> gnt1, alu inputs stable 3 cycles, done1 3 cycles after gnt1, res=0, cout=1.
- Contention: req0=req1=1 held for 4 ops -> grants 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN -> 0,0,0,0.
- Input churn: change a0 to 9 the cycle after gnt0 (a0=2,b0=2) -> alu_a stays 2, res=4.
- Abort: reset asserted one cycle into BUSY with HOLD=3 -> no done0/done1, busy=0, res=0 next cycle.

Source files
------------

// File: rtl/alu_arbiter2.sv
// alu_arbiter2: two-client arbiter sharing one ALU, round-robin unless ALU_ARB_FIXED_PRIO_EN is defined
module alu_arbiter2 #(
  parameter int WIDTH = 4,
  parameter int HOLD  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [1:0]       op0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [1:0]       op1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_cout,
  output logic             busy,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] res,
  output logic             cout
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic w_start, w_finish, w_win;
  if (HOLD < 1 || HOLD > 15) begin : g_hold_check
    $error("alu_arbiter2: HOLD must be within 1..15");
  end
`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_win = ~req0;
`else
  logic r_ptr;
  assign w_win = (req0 & req1) ? r_ptr : req1;
  always_ff @(posedge clk) r_ptr <= reset ? 1'b0 : (w_finish ? ~sel : r_ptr);
`endif
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  always_comb w_next = (r_state == IDLE) ? ((req0 | req1) ? BUSY : IDLE) : ((r_cnt == 4'd0) ? IDLE : BUSY);
  always_comb begin
    w_start  = (r_state == IDLE) && (req0 | req1);
    w_finish = (r_state == BUSY) && (r_cnt == 4'd0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      busy   <= 1'b0;
      sel    <= 1'b0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      res    <= '0;
      cout   <= 1'b0;
      r_cnt  <= 4'd0;
    end else begin
      gnt0  <= w_start & ~w_win;
      gnt1  <= w_start & w_win;
      done0 <= w_finish & ~sel;
      done1 <= w_finish & sel;
      busy  <= (w_next == BUSY);
      if (w_start) begin
        sel    <= w_win;
        alu_a  <= w_win ? a1 : a0;
        alu_b  <= w_win ? b1 : b0;
        alu_op <= w_win ? op1 : op0;
        r_cnt  <= 4'(HOLD - 1);
      end else if (r_state == BUSY && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      if (w_finish) begin
        res  <= alu_res;
        cout <= alu_cout;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter2.sv
// tb_alu_arbiter2: checks HOLD=1 and HOLD=3 instances against a transaction-level model
module tb_alu_arbiter2;
  localparam int W = 4;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic [1:0] op0, op1;
  logic [1:0] gnt0, gnt1, sel, busy, done0, done1, cout, alu_cout;
  logic [W-1:0] alu_a[2], alu_b[2], alu_res[2], res[2];
  logic [1:0] alu_op[2];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  function automatic logic [W:0] alu(input logic [W-1:0] a, b, input logic [1:0] op);
    return op == 2'd0 ? {1'b0, a} + {1'b0, b} :
           op == 2'd1 ? {1'b0, a} - {1'b0, b} :
           op == 2'd2 ? {1'b0, a & b} : {1'b0, a ^ b};
  endfunction
  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign {alu_cout[g], alu_res[g]} = alu(alu_a[g], alu_b[g], alu_op[g]);
    alu_arbiter2 #(.WIDTH(W), .HOLD(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .reset(reset),
      .req0(req0), .a0(a0), .b0(b0), .op0(op0),
      .req1(req1), .a1(a1), .b1(b1), .op1(op1),
      .gnt0(gnt0[g]), .gnt1(gnt1[g]), .sel(sel[g]),
      .alu_a(alu_a[g]), .alu_b(alu_b[g]), .alu_op(alu_op[g]),
      .alu_res(alu_res[g]), .alu_cout(alu_cout[g]),
      .busy(busy[g]), .done0(done0[g]), .done1(done1[g]),
      .res(res[g]), .cout(cout[g])
    );
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  int hold[2] = '{1, 3};
  bit m_live = 1'b0;
  bit m_busy[2], m_last[2], eg0[2], eg1[2], ed0[2], ed1[2], esel[2], ecout[2];
  int m_age[2];
  logic [W-1:0] ea[2], eb[2], eres[2];
  logic [1:0] eop[2];
  bit w;
  always @(posedge clk) begin
    if (reset) m_live = 1'b1;
    for (int i = 0; i < 2; i++) begin
      eg0[i] = 0; eg1[i] = 0; ed0[i] = 0; ed1[i] = 0;
      if (reset) begin
        m_busy[i] = 0; m_last[i] = 1; esel[i] = 0; ea[i] = 0; eb[i] = 0; eop[i] = 0; eres[i] = 0; ecout[i] = 0;
      end else if (!m_busy[i]) begin
        if (req0 || req1) begin
          w = (req0 && req1) ? (FIXED ? 1'b0 : !m_last[i]) : req1;
          esel[i] = w;
          ea[i] = w ? a1 : a0;
          eb[i] = w ? b1 : b0;
          eop[i] = w ? op1 : op0;
          eg0[i] = !w; eg1[i] = w;
          m_busy[i] = 1; m_age[i] = 0;
        end
      end else begin
        m_age[i]++;
        if (m_age[i] == hold[i]) begin
          {ecout[i], eres[i]} = alu(ea[i], eb[i], eop[i]);
          ed0[i] = !esel[i]; ed1[i] = esel[i];
          m_busy[i] = 0; m_last[i] = esel[i];
        end
      end
    end
  end
  always @(negedge clk) if (m_live) for (int i = 0; i < 2; i++)
    chk($sformatf("cycle_u%0d", i),
        32'({gnt0[i], gnt1[i], sel[i], busy[i], done0[i], done1[i], alu_op[i], alu_a[i], alu_b[i], res[i], cout[i]}),
        32'({eg0[i], eg1[i], esel[i], m_busy[i], ed0[i], ed1[i], eop[i], ea[i], eb[i], eres[i], ecout[i]}));
  task automatic wait_idle();
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (busy == 2'b00 && gnt0 == 2'b00 && gnt1 == 2'b00) return;
    end
    chk("idle_timeout", 1, 0);
  endtask
  task automatic wait_gnt();
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (gnt0[0] | gnt1[0]) return;
    end
    chk("gnt_timeout", 1, 0);
  endtask
  logic [3:0] seq;
  initial begin
    reset = 1; req0 = 1; a0 = 3; b0 = 4; op0 = 0; req1 = 0; a1 = 0; b1 = 0; op1 = 0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", {gnt0, gnt1}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res", {res[1], res[0]}, 0);
    reset = 0;
    @(negedge clk);
    chk("gnt0", gnt0, 2'b11);
    chk("sel0", sel, 0);
    chk("alu_a", alu_a[0], 3);
    chk("alu_b", alu_b[0], 4);
    req0 = 0;
    @(negedge clk);
    chk("done0_h1", done0, 2'b01);
    chk("res_h1", res[0], 7);
    chk("cout_h1", cout[0], 0);
    wait_idle();
    req1 = 1; a1 = 4'hF; b1 = 4'h1; op1 = 0;
    @(negedge clk);
    chk("gnt1", gnt1, 2'b11);
    req1 = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("hold_a", alu_a[1], 4'hF);
      chk("hold_done1", done1[1], 0);
    end
    @(negedge clk);
    chk("done1_h3", done1[1], 1);
    chk("res_h3", res[1], 0);
    chk("cout_h3", cout[1], 1);
    wait_idle();
    seq = FIXED ? 4'b0000 : 4'b1010;
    req0 = 1; req1 = 1; a0 = 1; b0 = 1; a1 = 2; b1 = 2;
    for (int k = 0; k < 4; k++) begin
      wait_gnt();
      chk($sformatf("contend_%0d", k), gnt1[0], seq[k]);
    end
    req0 = 0; req1 = 0;
    wait_idle();
    req0 = 1; a0 = 2; b0 = 2; op0 = 0;
    @(negedge clk);
    chk("churn_gnt", gnt0[0], 1);
    a0 = 9; req0 = 0;
    @(negedge clk);
    chk("churn_a", alu_a[0], 2);
    chk("churn_res", res[0], 4);
    chk("churn_done", done0[0], 1);
    wait_idle();
    req0 = 1; a0 = 5; b0 = 6;
    @(negedge clk);
    chk("abort_gnt", gnt0[1], 1);
    req0 = 0; reset = 1;
    @(negedge clk);
    chk("abort_busy", busy[1], 0);
    chk("abort_res", res[1], 0);
    chk("abort_done", {done0[1], done1[1]}, 0);
    reset = 0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_nodone", {done0[1], done1[1]}, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
